warp_scheduler: RTL

Per-core warp sequencer that drives every warp through the fetch/decode/request/wait/execute/update cycle. It owns each warp's program counter and the `warp_state`/`enable` inputs of the per-warp register files. It also round-robin arbitrates the single shared instruction-fetch port among warps waiting to fetch. It sits between the core's start/done control and the per-warp datapaths (`reg_file`, ALU, LSU, decoder).

---
 rtl/warp_scheduler_pkg.sv | 29 ++
 rtl/warp_scheduler_rr_arbiter.sv | 39 +++
 rtl/warp_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/warp_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// warp_scheduler_pkg
// Shared core types for the warp sequencer and the per-warp datapaths.
//   DATA_WIDTH    : default PC / data width (overridable with the macro)
//   data_t        : PC / data word
//   warp_state_t  : per-warp pipeline state, consumed by reg_file
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package warp_scheduler_pkg;

    localparam int DEFAULT_DATA_WIDTH = `DATA_WIDTH;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6,
        DONE    = 3'd7
    } warp_state_t;

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker for the shared fetch port.
//   req         in  N    one request bit per warp
//   last_grant  in  IW   index granted most recently
//   grant_valid out 1    at least one request present
//   grant_idx   out IW   first requester after last_grant (wrapping)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    int            cand;
    logic [IW-1:0] candIdx;

    // Walk the warps starting just after the last winner; the first
    // requester found wins, so the last winner has the lowest priority.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        candIdx     = '0;
        for (int k = 1; k <= N; k++) begin
            cand    = (int'(last_grant) + k) % N;
            candIdx = IW'(cand);
            if (!grant_valid && req[candIdx]) begin
                grant_valid = 1'b1;
                grant_idx   = candIdx;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// ---------------------------------------------------------------------------
// warp_scheduler
// Per-core warp sequencer: steps every warp through
// FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE, owns the warp PCs and
// round-robin arbitrates the single instruction-fetch port.
//   clk, reset      core clock, synchronous active-low reset
//   start/start_pc  launch pulse (only when all warps IDLE) and launch PC
//   warp_state      per-warp state to reg_file
//   warp_enable     per-warp enable (0 in IDLE/DONE)
//   pc              per-warp program counter
//   fetch_valid/fetch_warp/fetch_pc/fetch_done   fetch handshake
//   decoded_mem/decoded_halt   decoder flags per warp
//   lsu_done                   LSU completion per warp
//   branch_taken/branch_target redirect applied at UPDATE
//   done            all warps in DONE
// ---------------------------------------------------------------------------
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS  = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int IW         = $clog2(NUM_WARPS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [DATA_WIDTH-1:0]                 start_pc,
    output warp_state_t [NUM_WARPS-1:0]           warp_state,
    output logic [NUM_WARPS-1:0]                  warp_enable,
    output logic [NUM_WARPS-1:0][DATA_WIDTH-1:0]  pc,
    output logic                                  fetch_valid,
    output logic [IW-1:0]                         fetch_warp,
    output logic [DATA_WIDTH-1:0]                 fetch_pc,
    input  logic                                  fetch_done,
    input  logic [NUM_WARPS-1:0]                  decoded_mem,
    input  logic [NUM_WARPS-1:0]                  decoded_halt,
    input  logic [NUM_WARPS-1:0]                  lsu_done,
    input  logic [NUM_WARPS-1:0]                  branch_taken,
    input  logic [NUM_WARPS-1:0][DATA_WIDTH-1:0]  branch_target,
    output logic                                  done
);

    logic                  fetch_valid_q;
    logic [IW-1:0]         fetch_warp_q;
    logic [DATA_WIDTH-1:0] fetch_pc_q;
    logic [IW-1:0]         last_grant_q;

    logic [NUM_WARPS-1:0]  fetch_req;
    logic [NUM_WARPS-1:0]  idle_vec;
    logic [NUM_WARPS-1:0]  done_vec;
    logic                  all_idle;
    logic                  grant_valid;
    logic [IW-1:0]         grant_idx;

    assign all_idle = &idle_vec;

    // One FSM plus PC register per warp.
    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        warp_state_t           state_q;
        logic [DATA_WIDTH-1:0] pc_q;
        logic                  fetched;

        // Only the warp named by an outstanding fetch may consume fetch_done.
        assign fetched = fetch_valid_q && fetch_done && (fetch_warp_q == IW'(w));

        // Per-warp pipeline sequencing; DONE is terminal until reset and a
        // halt at UPDATE beats any branch redirect.
        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q <= IDLE;
                pc_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && all_idle) begin
                            state_q <= FETCH;
                            pc_q    <= start_pc;
                        end
                    end
                    FETCH:   if (fetched) state_q <= DECODE;
                    DECODE:  state_q <= REQUEST;
                    REQUEST: state_q <= WAIT;
                    WAIT:    if (!decoded_mem[w] || lsu_done[w]) state_q <= EXECUTE;
                    EXECUTE: state_q <= UPDATE;
                    UPDATE: begin
                        if (decoded_halt[w]) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= FETCH;
                            pc_q    <= branch_taken[w] ? branch_target[w]
                                                       : pc_q + DATA_WIDTH'(1);
                        end
                    end
                    DONE:    state_q <= DONE;
                endcase
            end
        end

        assign warp_state[w]  = state_q;
        assign pc[w]          = pc_q;
        assign warp_enable[w] = (state_q != IDLE) && (state_q != DONE);
        assign fetch_req[w]   = (state_q == FETCH);
        assign idle_vec[w]    = (state_q == IDLE);
        assign done_vec[w]    = (state_q == DONE);
    end

    rr_arbiter #(
        .N  (NUM_WARPS),
        .IW (IW)
    ) u_arbiter (
        .req         (fetch_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Fetch port: a new grant is only taken while no fetch is outstanding,
    // so there is always an idle cycle between consecutive grants. The
    // granted warp and PC are frozen until fetch_done arrives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_valid_q <= 1'b0;
            fetch_warp_q  <= '0;
            fetch_pc_q    <= '0;
            last_grant_q  <= IW'(NUM_WARPS - 1);
        end else if (fetch_valid_q) begin
            if (fetch_done) begin
                fetch_valid_q <= 1'b0;
            end
        end else if (grant_valid) begin
            fetch_valid_q <= 1'b1;
            fetch_warp_q  <= grant_idx;
            fetch_pc_q    <= pc[grant_idx];
            last_grant_q  <= grant_idx;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_warp  = fetch_warp_q;
    assign fetch_pc    = fetch_pc_q;
    assign done        = &done_vec;

endmodule
